// File: rtl/key_cursor.sv
// Key-driven cursor: debounces a 3-bit key code, emits press and
// auto-repeat step events over a valid/ready handshake, and moves a
// wrapping (x, y) cursor on every accepted event.
module key_cursor #(
  parameter int DEB_CYCLES = 16,
  parameter int REP_DELAY  = 1000,
  parameter int REP_PERIOD = 250,
  parameter int COLS       = 64,
  parameter int ROWS       = 48,
  localparam int X_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int Y_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     keys,
  output logic           ev_valid,
  output logic [2:0]     ev_key,
  input  logic           ev_ready,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y
);

  // Key encoding shared with the touch front-end (key_codes.vh)
  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;

  localparam int DC_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RC_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  localparam logic [DC_W-1:0] DEB_MAX    = DC_W'(DEB_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LOAD = RC_W'(REP_DELAY - 1);
  localparam logic [RC_W-1:0] PER_LOAD   = RC_W'(REP_PERIOD - 1);
  localparam logic [X_W-1:0]  X_MAX      = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]  Y_MAX      = Y_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [2:0]      keysS_q;
  logic [DC_W-1:0] stabCnt_q;
  logic [2:0]      debKey_q;
  state_t          state_q;
  logic [RC_W-1:0] repCnt_q;
  logic [2:0]      curKey_q;
  logic            evValid_q;
  logic [2:0]      evKey_q;
  logic [X_W-1:0]  cursorX_q;
  logic [Y_W-1:0]  cursorY_q;

  logic [2:0]      keysNorm;
  logic            pressEv;
  logic            repEv;
  logic            genEv;
  logic            canIssue;
  logic [X_W-1:0]  cursorX_d;
  logic [Y_W-1:0]  cursorY_d;

  // Codes outside the four direction keys count as "no key"
  always_comb begin
    keysNorm = KEY_NONE;
    if (keysS_q != KEY_NONE && keysS_q <= KEY_RIGHT) keysNorm = keysS_q;
  end

  // Synchronise the raw key code and accept it once it has been stable long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      keysS_q   <= KEY_NONE;
      stabCnt_q <= '0;
      debKey_q  <= KEY_NONE;
    end else begin
      keysS_q <= keys;
      if (keys != keysS_q) stabCnt_q <= '0;
      else if (stabCnt_q != DEB_MAX) stabCnt_q <= stabCnt_q + DC_W'(1);
      if (stabCnt_q == DEB_MAX) debKey_q <= keysNorm;
    end
  end

  // Event sources and the cursor position an accepted event would produce
  always_comb begin
    pressEv   = (debKey_q != KEY_NONE) && (debKey_q != curKey_q);
    repEv     = (state_q != IDLE) && (debKey_q == curKey_q) && (repCnt_q == '0);
    genEv     = pressEv || repEv;
    canIssue  = !evValid_q || ev_ready;
    cursorX_d = cursorX_q;
    cursorY_d = cursorY_q;
    case (debKey_q)
      KEY_RIGHT: cursorX_d = (cursorX_q == X_MAX) ? '0 : cursorX_q + X_W'(1);
      KEY_LEFT:  cursorX_d = (cursorX_q == '0) ? X_MAX : cursorX_q - X_W'(1);
      KEY_DOWN:  cursorY_d = (cursorY_q == Y_MAX) ? '0 : cursorY_q + Y_W'(1);
      KEY_UP:    cursorY_d = (cursorY_q == '0) ? Y_MAX : cursorY_q - Y_W'(1);
      default:   ;
    endcase
  end

  // Repeat FSM with registered event handshake and cursor; events hitting a stalled consumer are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      repCnt_q  <= '0;
      curKey_q  <= KEY_NONE;
      evValid_q <= 1'b0;
      evKey_q   <= KEY_NONE;
      cursorX_q <= '0;
      cursorY_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pressEv) begin
            state_q  <= DELAY;
            repCnt_q <= DELAY_LOAD;
            curKey_q <= debKey_q;
          end
        end
        DELAY, REPEAT: begin
          if (debKey_q == KEY_NONE) begin
            state_q  <= IDLE;
            curKey_q <= KEY_NONE;
          end else if (pressEv) begin
            state_q  <= DELAY;
            repCnt_q <= DELAY_LOAD;
            curKey_q <= debKey_q;
          end else if (repCnt_q == '0) begin
            state_q  <= REPEAT;
            repCnt_q <= PER_LOAD;
          end else begin
            repCnt_q <= repCnt_q - RC_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          curKey_q <= KEY_NONE;
        end
      endcase

      if (genEv && canIssue) begin
        evValid_q <= 1'b1;
        evKey_q   <= debKey_q;
        cursorX_q <= cursorX_d;
        cursorY_q <= cursorY_d;
      end else if (evValid_q && ev_ready) begin
        evValid_q <= 1'b0;
      end
    end
  end

  assign ev_valid = evValid_q;
  assign ev_key   = evKey_q;
  assign cursor_x = cursorX_q;
  assign cursor_y = cursorY_q;

endmodule

// File: tb/tb_key_cursor.sv
// Scoreboard bench for key_cursor: every expected step event (key, cursor
// position, arrival cycle) is queued when stimulus is driven and matched
// against the events a monitor captures from the handshake.
module tb_key_cursor;

  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;

  typedef struct packed {
    logic [2:0]  key;
    logic [2:0]  x;
    logic [1:0]  y;
    logic [31:0] cyc;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [2:0] keys;
  logic       ev_valid;
  logic [2:0] ev_key;
  logic       ev_ready;
  logic [2:0] cursor_x;
  logic [1:0] cursor_y;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  ev_t expQ[$];
  ev_t obsQ[$];
  logic prevV = 1'b0;
  logic prevR = 1'b0;

  key_cursor #(
    .DEB_CYCLES(4), .REP_DELAY(20), .REP_PERIOD(8), .COLS(5), .ROWS(3)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys),
    .ev_valid(ev_valid), .ev_key(ev_key), .ev_ready(ev_ready),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to time events
  always @(posedge clk) cyc <= cyc + 1;

  // Capture each newly issued event at the falling edge
  always @(negedge clk) begin
    if (!reset && ev_valid && (!prevV || prevR))
      obsQ.push_back('{key: ev_key, x: cursor_x, y: cursor_y, cyc: 32'(cyc)});
    prevV = ev_valid && !reset;
    prevR = ev_ready;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; keys = 3'd0; ev_ready = 1'b1;
    waitCycles(2);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0d want 0", ev_valid); end
    total++; if (ev_key !== 3'd0) begin bad++; $display("[TB] FAIL reset_key: got %0d want 0", ev_key); end
    total++; if (cursor_x !== 3'd0) begin bad++; $display("[TB] FAIL reset_x: got %0d want 0", cursor_x); end
    total++; if (cursor_y !== 2'd0) begin bad++; $display("[TB] FAIL reset_y: got %0d want 0", cursor_y); end
    reset = 1'b0;
    waitCycles(2);
  endtask

  task automatic test_glitch();
    keys = KEY_RIGHT;
    waitCycles(3);
    keys = 3'd0;
    waitCycles(12);
    keys = 3'd5;
    waitCycles(10);
    keys = 3'd0;
    waitCycles(12);
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL glitch_events: got %0d want 0", obsQ.size()); end
    total++; if (cursor_x !== 3'd0) begin bad++; $display("[TB] FAIL glitch_x: got %0d want 0", cursor_x); end
    total++; if (cursor_y !== 2'd0) begin bad++; $display("[TB] FAIL glitch_y: got %0d want 0", cursor_y); end
    obsQ.delete();
  endtask

  task automatic test_single_press();
    int t0;
    int n;
    ev_t e, o;
    ev_ready = 1'b1;
    keys = KEY_RIGHT; t0 = cyc;
    expQ.push_back('{key: KEY_RIGHT, x: 3'd1, y: 2'd0, cyc: 32'(t0 + 6)});
    waitCycles(10);
    keys = 3'd0;
    waitCycles(15);
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin bad++; $display("[TB] FAIL single_press ev%0d: got none want key=%0d cyc=%0d", i, e.key, e.cyc); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL single_press ev%0d: got key=%0d x=%0d y=%0d cyc=%0d want key=%0d x=%0d y=%0d cyc=%0d", i, o.key, o.x, o.y, o.cyc, e.key, e.x, e.y, e.cyc); end
      end
    end
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL single_press_extra: got %0d want 0", obsQ.size()); end
    total++; if (cursor_x !== 3'd1) begin bad++; $display("[TB] FAIL single_press_x: got %0d want 1", cursor_x); end
    obsQ.delete();
  endtask

  task automatic test_repeat_wrap();
    int t0;
    int n;
    ev_t e, o;
    logic [2:0] xs [6];
    int offs [6];
    xs   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    offs = '{6, 26, 34, 42, 50, 58};
    applyReset();
    ev_ready = 1'b1;
    keys = KEY_RIGHT; t0 = cyc;
    for (int i = 0; i < 6; i++)
      expQ.push_back('{key: KEY_RIGHT, x: xs[i], y: 2'd0, cyc: 32'(t0 + offs[i])});
    waitCycles(55);
    keys = 3'd0;
    waitCycles(15);
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin bad++; $display("[TB] FAIL repeat_wrap ev%0d: got none want key=%0d cyc=%0d", i, e.key, e.cyc); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL repeat_wrap ev%0d: got key=%0d x=%0d y=%0d cyc=%0d want key=%0d x=%0d y=%0d cyc=%0d", i, o.key, o.x, o.y, o.cyc, e.key, e.x, e.y, e.cyc); end
      end
    end
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL repeat_wrap_extra: got %0d want 0", obsQ.size()); end
    obsQ.delete();
  endtask

  task automatic test_backpressure();
    int t0;
    int n;
    ev_t e, o;
    applyReset();
    ev_ready = 1'b0;
    keys = KEY_DOWN; t0 = cyc;
    expQ.push_back('{key: KEY_DOWN, x: 3'd0, y: 2'd1, cyc: 32'(t0 + 6)});
    waitCycles(10);
    total++; if (ev_valid !== 1'b1 || ev_key !== KEY_DOWN) begin bad++; $display("[TB] FAIL bp_hold_early: got valid=%0d key=%0d want valid=1 key=%0d", ev_valid, ev_key, KEY_DOWN); end
    waitCycles(20);
    total++; if (ev_valid !== 1'b1 || ev_key !== KEY_DOWN) begin bad++; $display("[TB] FAIL bp_hold_late: got valid=%0d key=%0d want valid=1 key=%0d", ev_valid, ev_key, KEY_DOWN); end
    total++; if (cursor_y !== 2'd1) begin bad++; $display("[TB] FAIL bp_y: got %0d want 1", cursor_y); end
    total++; if (cursor_x !== 3'd0) begin bad++; $display("[TB] FAIL bp_x: got %0d want 0", cursor_x); end
    waitCycles(10);
    keys = 3'd0;
    waitCycles(15);
    ev_ready = 1'b1;
    waitCycles(2);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release: got %0d want 0", ev_valid); end
    total++; if (cursor_y !== 2'd1) begin bad++; $display("[TB] FAIL bp_y_final: got %0d want 1", cursor_y); end
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin bad++; $display("[TB] FAIL backpressure ev%0d: got none want key=%0d cyc=%0d", i, e.key, e.cyc); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL backpressure ev%0d: got key=%0d x=%0d y=%0d cyc=%0d want key=%0d x=%0d y=%0d cyc=%0d", i, o.key, o.x, o.y, o.cyc, e.key, e.x, e.y, e.cyc); end
      end
    end
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL backpressure_extra: got %0d want 0", obsQ.size()); end
    obsQ.delete();
  endtask

  task automatic test_key_change();
    int t0, t1;
    int n;
    ev_t e, o;
    applyReset();
    ev_ready = 1'b1;
    keys = KEY_UP; t0 = cyc;
    expQ.push_back('{key: KEY_UP, x: 3'd0, y: 2'd2, cyc: 32'(t0 + 6)});
    waitCycles(15);
    keys = KEY_LEFT; t1 = cyc;
    expQ.push_back('{key: KEY_LEFT, x: 3'd4, y: 2'd2, cyc: 32'(t1 + 6)});
    expQ.push_back('{key: KEY_LEFT, x: 3'd3, y: 2'd2, cyc: 32'(t1 + 26)});
    waitCycles(27);
    keys = 3'd0;
    waitCycles(15);
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin bad++; $display("[TB] FAIL key_change ev%0d: got none want key=%0d cyc=%0d", i, e.key, e.cyc); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL key_change ev%0d: got key=%0d x=%0d y=%0d cyc=%0d want key=%0d x=%0d y=%0d cyc=%0d", i, o.key, o.x, o.y, o.cyc, e.key, e.x, e.y, e.cyc); end
      end
    end
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL key_change_extra: got %0d want 0", obsQ.size()); end
    obsQ.delete();
  endtask

  task automatic test_reset_midrepeat();
    int t0;
    int n;
    ev_t e, o;
    applyReset();
    ev_ready = 1'b0;
    keys = KEY_RIGHT; t0 = cyc;
    expQ.push_back('{key: KEY_RIGHT, x: 3'd1, y: 2'd0, cyc: 32'(t0 + 6)});
    waitCycles(30);
    total++; if (ev_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrep_pending: got %0d want 1", ev_valid); end
    reset = 1'b1; ev_ready = 1'b1;
    waitCycles(1);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrep_valid: got %0d want 0", ev_valid); end
    total++; if (ev_key !== 3'd0) begin bad++; $display("[TB] FAIL midrep_key: got %0d want 0", ev_key); end
    total++; if (cursor_x !== 3'd0) begin bad++; $display("[TB] FAIL midrep_x: got %0d want 0", cursor_x); end
    total++; if (cursor_y !== 2'd0) begin bad++; $display("[TB] FAIL midrep_y: got %0d want 0", cursor_y); end
    reset = 1'b0;
    waitCycles(5);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrep_early_event: got %0d want 0", ev_valid); end
    expQ.push_back('{key: KEY_RIGHT, x: 3'd1, y: 2'd0, cyc: 32'(t0 + 37)});
    waitCycles(9);
    keys = 3'd0;
    waitCycles(15);
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin bad++; $display("[TB] FAIL reset_midrepeat ev%0d: got none want key=%0d cyc=%0d", i, e.key, e.cyc); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL reset_midrepeat ev%0d: got key=%0d x=%0d y=%0d cyc=%0d want key=%0d x=%0d y=%0d cyc=%0d", i, o.key, o.x, o.y, o.cyc, e.key, e.x, e.y, e.cyc); end
      end
    end
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL reset_midrepeat_extra: got %0d want 0", obsQ.size()); end
    obsQ.delete();
  endtask

  // Scenario sequence
  initial begin
    reset = 1'b1; keys = 3'd0; ev_ready = 1'b1;
    test_reset();
    test_glitch();
    test_single_press();
    test_repeat_wrap();
    test_backpressure();
    test_key_change();
    test_reset_midrepeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
